// File: rtl/uart_tx_registers_pkg.sv
// Shared register map, bit positions and transmit FSM encoding for the UART TX slave.
// Pure declarations: no logic, no latency, no flow control.
package uart_tx_registers_pkg;

  localparam logic [3:0] TXDATA_OFF  = 4'h0;
  localparam logic [3:0] STATUS_OFF  = 4'h4;
  localparam logic [3:0] BAUDDIV_OFF = 4'h8;
  localparam logic [3:0] CTRL_OFF    = 4'hC;

  localparam int ST_FULL    = 0;
  localparam int ST_EMPTY   = 1;
  localparam int ST_BUSY    = 2;
  localparam int ST_TX_IDLE = 3;
  localparam int ST_OVF     = 4;
  localparam int ST_CNT_LSB = 8;

  localparam int CTRL_TX_EN  = 0;
  localparam int CTRL_IRQ_EN = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } tx_state_e;

  function automatic logic [31:0] pack_status(
    input logic       full,
    input logic       empty,
    input logic       busy,
    input logic       ovf,
    input logic [7:0] count
  );
    logic [31:0] w;
    w                    = '0;
    w[ST_FULL]           = full;
    w[ST_EMPTY]          = empty;
    w[ST_BUSY]           = busy;
    w[ST_TX_IDLE]        = empty & ~busy;
    w[ST_OVF]            = ovf;
    w[ST_CNT_LSB +: 8]   = count;
    return w;
  endfunction

endpackage

// File: rtl/uart_tx_registers_sync_fifo.sv
// Synchronous byte FIFO; push/pop take effect on the next edge, dout shows the head combinationally.
// A push into a full FIFO is accepted only when a pop happens in the same cycle, otherwise dropped.
module uart_tx_registers_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty,
  output logic [CW-1:0]    o_count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push_ok;
  logic             w_pop_ok;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_dout  = r_mem[r_rd_ptr];

  // When full, the write slot equals the read slot; the head leaves on the same edge.
  assign w_pop_ok  = i_pop & ~o_empty;
  assign w_push_ok = i_push & (~o_full | w_pop_ok);

  always_ff @(posedge i_clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_push_ok && !w_pop_ok) begin
        r_count <= r_count + CW'(1);
      end else if (w_pop_ok && !w_push_ok) begin
        r_count <= r_count - CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_tx_registers.sv
// Memory-mapped 8N1 UART transmitter: register writes land on the next edge, reads are combinational.
// No bus stall; TX FIFO overruns drop the byte and set a sticky overflow flag.
module uart_tx_registers
  import uart_tx_registers_pkg::*;
#(
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [15:0] DEFAULT_DIV = 16'd867
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        csb_i,
  input  logic        wen_i,
  input  logic [3:0]  addr_i,
  input  logic [31:0] data_i,
  input  logic [3:0]  wmask_i,
  output logic [31:0] data_o,
  output logic        irq_o,
  output logic        tx_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  localparam logic [1:0] SEL_TXDATA  = TXDATA_OFF[3:2];
  localparam logic [1:0] SEL_STATUS  = STATUS_OFF[3:2];
  localparam logic [1:0] SEL_BAUDDIV = BAUDDIV_OFF[3:2];
  localparam logic [1:0] SEL_CTRL    = CTRL_OFF[3:2];

  logic [15:0]   r_bauddiv;
  logic          r_tx_en;
  logic          r_irq_en;
  logic          r_ovf;
  logic          r_irq;

  tx_state_e     r_state;
  tx_state_e     w_state_nxt;
  logic [15:0]   r_baud_cnt;
  logic [15:0]   w_baud_cnt_nxt;
  logic [2:0]    r_bit_idx;
  logic [2:0]    w_bit_idx_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic          r_tx;
  logic          w_tx_nxt;

  logic          w_wr;
  logic [1:0]    w_sel;
  logic          w_push;
  logic          w_pop;
  logic          w_ovf_clr;
  logic          w_bit_end;
  logic          w_start_ok;
  logic          w_busy;
  logic          w_tx_idle;
  logic [7:0]    w_fifo_dout;
  logic          w_full;
  logic          w_empty;
  logic [CW-1:0] w_count;
  logic [31:0]   w_status;
  logic [31:0]   w_rdata;
  logic          w_unused;

  assign w_unused = &{1'b0, addr_i[1:0], data_i[31:16], wmask_i[3:2]};

  assign w_wr      = ~csb_i & ~wen_i;
  assign w_sel     = addr_i[3:2];
  assign w_push    = w_wr & (w_sel == SEL_TXDATA) & wmask_i[0];
  assign w_ovf_clr = w_wr & (w_sel == SEL_STATUS) & wmask_i[0] & data_i[ST_OVF];

  uart_tx_registers_sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (clk_i),
    .i_reset (reset_i),
    .i_push  (w_push),
    .i_din   (data_i[7:0]),
    .i_pop   (w_pop),
    .o_dout  (w_fifo_dout),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  assign w_busy     = (r_state != S_IDLE);
  assign w_tx_idle  = w_empty & ~w_busy;
  assign w_start_ok = r_tx_en & ~w_empty;
  // Greater-or-equal also ends the bit when a divisor below the running count is written mid-bit.
  assign w_bit_end  = (r_baud_cnt >= r_bauddiv);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_bauddiv <= DEFAULT_DIV;
      r_tx_en   <= 1'b0;
      r_irq_en  <= 1'b0;
      r_ovf     <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (w_wr && (w_sel == SEL_BAUDDIV)) begin
        if (wmask_i[0]) begin
          r_bauddiv[7:0] <= data_i[7:0];
        end
        if (wmask_i[1]) begin
          r_bauddiv[15:8] <= data_i[15:8];
        end
      end
      if (w_wr && (w_sel == SEL_CTRL) && wmask_i[0]) begin
        r_tx_en  <= data_i[CTRL_TX_EN];
        r_irq_en <= data_i[CTRL_IRQ_EN];
      end
      if (w_push && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end else if (w_ovf_clr) begin
        r_ovf <= 1'b0;
      end
      r_irq <= r_irq_en & w_tx_idle;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_baud_cnt <= w_baud_cnt_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_shift    <= w_shift_nxt;
      r_tx       <= w_tx_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_baud_cnt_nxt = r_baud_cnt + 16'd1;
    w_bit_idx_nxt  = r_bit_idx;
    w_shift_nxt    = r_shift;
    w_pop          = 1'b0;
    w_tx_nxt       = 1'b1;

    unique case (r_state)
      S_IDLE: begin
        w_baud_cnt_nxt = '0;
        if (w_start_ok) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_fifo_dout;
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_baud_cnt_nxt = '0;
          w_bit_idx_nxt  = '0;
          w_state_nxt    = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_baud_cnt_nxt = '0;
          w_shift_nxt    = {1'b0, r_shift[7:1]};
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = S_STOP;
          end else begin
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_baud_cnt_nxt = '0;
          // Chain straight into the next start bit so frames are back-to-back.
          if (w_start_ok) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_fifo_dout;
            w_state_nxt = S_START;
          end else begin
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    unique case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_shift_nxt[0];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  assign w_status = pack_status(w_full, w_empty, w_busy, r_ovf, 8'(w_count));

  always_comb begin
    w_rdata = '0;
    if (!csb_i) begin
      unique case (w_sel)
        SEL_STATUS:  w_rdata = w_status;
        SEL_BAUDDIV: w_rdata = {16'd0, r_bauddiv};
        SEL_CTRL:    w_rdata = {30'd0, r_irq_en, r_tx_en};
        default:     w_rdata = '0;
      endcase
    end
  end

  assign data_o = w_rdata;
  assign irq_o  = r_irq;
  assign tx_o   = r_tx;

endmodule
